// File: rtl/multi_edge_sync.sv
// Multi-channel input conditioner: two-flop synchronizer, tick-paced glitch filter,
// edge pulses, sticky edge flags and a combined, registered interrupt request.
module multi_edge_sync #(
  parameter int unsigned       CH_NUM       = 8,
  parameter int unsigned       FILTER_DEPTH = 4,
  parameter logic [CH_NUM-1:0] INIT_VAL     = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic [CH_NUM-1:0] signal_in,
  input  logic [CH_NUM-1:0] rise_en,
  input  logic [CH_NUM-1:0] fall_en,
  input  logic [CH_NUM-1:0] flag_clear,
  output logic [CH_NUM-1:0] signal_out,
  output logic [CH_NUM-1:0] rise_pulse,
  output logic [CH_NUM-1:0] fall_pulse,
  output logic [CH_NUM-1:0] rise_flag,
  output logic [CH_NUM-1:0] fall_flag,
  output logic              irq
);

  localparam int unsigned     CW       = $clog2(FILTER_DEPTH + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_DEPTH - 1);

  logic [CH_NUM-1:0]         sync1_q, sync2_q;
  logic [CH_NUM-1:0]         signal_out_q, signal_out_d;
  logic [CH_NUM-1:0]         rise_pulse_q, rise_pulse_d;
  logic [CH_NUM-1:0]         fall_pulse_q, fall_pulse_d;
  logic [CH_NUM-1:0]         rise_flag_q, rise_flag_d;
  logic [CH_NUM-1:0]         fall_flag_q, fall_flag_d;
  logic [CH_NUM-1:0][CW-1:0] cnt_q, cnt_d;
  logic                      irq_q, irq_d;

  always_comb begin
    signal_out_d = signal_out_q;
    rise_pulse_d = '0;
    fall_pulse_d = '0;
    cnt_d        = cnt_q;
    if (tick) begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        if (sync2_q[i] == signal_out_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] >= CNT_LAST) begin
          // Last qualifying tick: accept the new level on this same edge.
          signal_out_d[i] = sync2_q[i];
          cnt_d[i]        = '0;
          rise_pulse_d[i] = sync2_q[i];
          fall_pulse_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    // A set event on the same edge as a clear takes priority.
    rise_flag_d = (rise_flag_q & ~flag_clear) | rise_pulse_d;
    fall_flag_d = (fall_flag_q & ~flag_clear) | fall_pulse_d;
    irq_d       = |((rise_flag_q & rise_en) | (fall_flag_q & fall_en));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= INIT_VAL;
      sync2_q      <= INIT_VAL;
      signal_out_q <= INIT_VAL;
      rise_pulse_q <= '0;
      fall_pulse_q <= '0;
      rise_flag_q  <= '0;
      fall_flag_q  <= '0;
      cnt_q        <= '0;
      irq_q        <= 1'b0;
    end else begin
      sync1_q      <= signal_in;
      sync2_q      <= sync1_q;
      signal_out_q <= signal_out_d;
      rise_pulse_q <= rise_pulse_d;
      fall_pulse_q <= fall_pulse_d;
      rise_flag_q  <= rise_flag_d;
      fall_flag_q  <= fall_flag_d;
      cnt_q        <= cnt_d;
      irq_q        <= irq_d;
    end
  end

  assign signal_out = signal_out_q;
  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;
  assign rise_flag  = rise_flag_q;
  assign fall_flag  = fall_flag_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_multi_edge_sync.sv
// Bench for multi_edge_sync: directed scenarios followed by random traffic, all
// checked against a run-length reference model of the filter rules.
module tb_multi_edge_sync;

  localparam int         CH   = 4;
  localparam int         FD   = 3;
  localparam logic [3:0] INIT = 4'b1000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tick;
  logic [CH-1:0] signal_in, rise_en, fall_en, flag_clear;
  logic [CH-1:0] signal_out, rise_pulse, fall_pulse, rise_flag, fall_flag;
  logic          irq;

  multi_edge_sync #(.CH_NUM(CH), .FILTER_DEPTH(FD), .INIT_VAL(INIT)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .signal_in(signal_in),
    .rise_en(rise_en), .fall_en(fall_en), .flag_clear(flag_clear),
    .signal_out(signal_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .rise_flag(rise_flag), .fall_flag(fall_flag), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  bit tick_periodic = 1'b1;

  // Reference model state: input history, accepted level, mismatch run lengths.
  logic [CH-1:0] m_s1, m_s2, m_out, m_rp, m_fp, m_rf, m_ff;
  logic          m_irq;
  int            m_run [CH];

  logic [CH-1:0] acc_rp, acc_fp;
  logic          acc_irq, next_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = INIT; m_s2 = INIT; m_out = INIT;
    m_rp = '0; m_fp = '0; m_rf = '0; m_ff = '0; m_irq = 1'b0;
    for (int i = 0; i < CH; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [CH-1:0] rp, fp;
    logic          irq_n;
    if (!reset_n) begin
      model_reset();
      return;
    end
    irq_n = |((m_rf & rise_en) | (m_ff & fall_en));
    rp = '0; fp = '0;
    if (tick) begin
      for (int i = 0; i < CH; i++) begin
        if (m_s2[i] !== m_out[i]) begin
          m_run[i]++;
          if (m_run[i] == FD) begin
            m_out[i] = m_s2[i];
            m_run[i] = 0;
            if (m_s2[i]) rp[i] = 1'b1; else fp[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = signal_in;
    m_rp = rp; m_fp = fp;
    m_rf = (m_rf & ~flag_clear) | rp;
    m_ff = (m_ff & ~flag_clear) | fp;
    m_irq = irq_n;
  endtask

  task automatic check_all();
    chk("signal_out", signal_out, m_out);
    chk("rise_pulse", rise_pulse, m_rp);
    chk("fall_pulse", fall_pulse, m_fp);
    chk("rise_flag", rise_flag, m_rf);
    chk("fall_flag", fall_flag, m_ff);
    chk("irq", irq, m_irq);
  endtask

  task automatic step();
    int nxt;
    nxt = edge_n + 1;
    if (tick_periodic) tick = (nxt % 4 == 0);
    else tick = 1'($urandom_range(0, 1));
    @(posedge clk);
    edge_n = nxt;
    model_edge();
    #1;
    check_all();
  endtask

  // Inputs changed just after edge e0: sync sees them after e0+2, so the first
  // qualifying tick is at or after e0+3 and acceptance comes FD-1 ticks later.
  task automatic expect_accept(input int ch, input bit rise, input bit clr);
    int t, acc, got, npulse;
    t = edge_n + 3;
    while (t % 4 != 0) t++;
    acc = t + 4 * (FD - 1);
    got = -1; npulse = 0;
    acc_irq = 1'bx; next_irq = 1'bx;
    for (int k = 0; k < 60 && edge_n < acc + 2; k++) begin
      if (clr && edge_n == acc - 1) flag_clear[ch] = 1'b1;
      step();
      if (clr) flag_clear[ch] = 1'b0;
      if ((rise ? rise_pulse[ch] : fall_pulse[ch]) === 1'b1) begin
        npulse++;
        if (got < 0) got = edge_n;
      end
      if (edge_n == acc) begin acc_rp = rise_pulse; acc_fp = fall_pulse; acc_irq = irq; end
      if (edge_n == acc + 1) next_irq = irq;
    end
    chk("accept_edge", got, acc);
    chk("pulse_count", npulse, 1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; tick = 1'b0; signal_in = INIT;
    rise_en = '0; fall_en = '0; flag_clear = '0;
    model_reset();
    repeat (3) step();
    chk("reset_out", signal_out, INIT);
    reset_n = 1'b1;

    n = 0;
    repeat (20) begin
      step();
      if (rise_pulse != 0 || fall_pulse != 0 || rise_flag != 0 || fall_flag != 0) n++;
    end
    chk("post_reset_quiet", n, 0);

    // ch0 rise with periodic tick
    rise_en = 4'b0001; fall_en = 4'b0000;
    signal_in[0] = 1'b1;
    expect_accept(0, 1'b1, 1'b0);
    chk("rise0_flag", rise_flag[0], 1'b1);
    chk("rise0_out", signal_out[0], 1'b1);
    chk("irq_at_accept", acc_irq, 1'b0);
    chk("irq_next", next_irq, 1'b1);

    // ch1 glitch covering two ticks only
    while (edge_n % 4 != 0) step();
    n = 0;
    signal_in[1] = 1'b1;
    repeat (8) begin step(); if (rise_pulse[1] || fall_pulse[1]) n++; end
    signal_in[1] = 1'b0;
    repeat (8) begin step(); if (rise_pulse[1] || fall_pulse[1]) n++; end
    chk("glitch_pulses", n, 0);
    chk("glitch_out", signal_out[1], 1'b0);
    signal_in[1] = 1'b1;
    expect_accept(1, 1'b1, 1'b0);

    // simultaneous rise ch2 / fall ch3
    signal_in[2] = 1'b1; signal_in[3] = 1'b0;
    expect_accept(2, 1'b1, 1'b0);
    chk("simul_rise", acc_rp, 4'b0100);
    chk("simul_fall", acc_fp, 4'b1000);

    // clear coinciding with a new rise, then clear alone
    signal_in[0] = 1'b0;
    expect_accept(0, 1'b0, 1'b0);
    signal_in[0] = 1'b1;
    expect_accept(0, 1'b1, 1'b1);
    chk("set_wins", rise_flag[0], 1'b1);
    flag_clear = 4'b0001;
    step();
    flag_clear = '0;
    chk("clear_flag", rise_flag[0], 1'b0);
    chk("irq_before_update", irq, 1'b1);
    step();
    chk("irq_after_clear", irq, 1'b0);

    // reset in the middle of qualification
    signal_in[0] = 1'b0;
    expect_accept(0, 1'b0, 1'b0);
    signal_in[0] = 1'b1;
    repeat (10) step();
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_reset_out", signal_out, INIT);
    repeat (2) step();
    reset_n = 1'b1;
    expect_accept(0, 1'b1, 1'b0);

    // enable gating of irq
    rise_en = '0; fall_en = '0;
    repeat (2) step();
    chk("irq_masked", irq, 1'b0);
    chk("flag_kept", rise_flag[0], 1'b1);
    rise_en = 4'b0001;
    step();
    chk("irq_enabled", irq, 1'b1);

    // random traffic
    tick_periodic = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) signal_in[$urandom_range(0, CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 31) == 0) begin
        rise_en = 4'($urandom); fall_en = 4'($urandom);
      end
      flag_clear = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 499) == 0) begin
        #1 reset_n = 1'b0;
        model_reset();
        #1 check_all();
        #1 reset_n = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
